// File: rtl/shift_seq_pkg.sv
// Shared op codes, slice mode encodings and FSM states for the shift sequencer.
// Optional CARRY output is enabled by SHIFT_SEQ_CARRY_EN in shift_seq_ctrl.
package shift_seq_pkg;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_ROR;
  endfunction

  function automatic logic op_left(input logic [2:0] op);
    return (op == OP_SLL) || (op == OP_ROL);
  endfunction

  function automatic logic [1:0] shift_mode(input logic [2:0] op);
    return op_left(op) ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_cnt.sv
// Loadable down-counter tracking remaining bit steps; last flags count == 1.
module shift_cnt #(
  parameter int AMT_W = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             load,
  input  logic [AMT_W-1:0] load_val,
  input  logic             en,
  output logic [AMT_W-1:0] count,
  output logic             last
);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)                      count <= '0;
    else if (load)                  count <= load_val;
    else if (en && (count != '0))   count <= count - 1'b1;
  end

  assign last = (count == AMT_W'(1));

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequencer for a bank of 4-bit universal shift slices: drives S1/S0 and end serial inputs.
// Define SHIFT_SEQ_CARRY_EN to add the CARRY output (last bit shifted/rotated out).
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AMT_W = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             START,
  input  logic [2:0]       OP,
  input  logic [AMT_W-1:0] AMT,
  input  logic             STALL,
  input  logic [WIDTH-1:0] REG_Q,
  output logic             S1,
  output logic             S0,
  output logic             LIN,
  output logic             RIN,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR
`ifdef SHIFT_SEQ_CARRY_EN
  ,
  output logic             CARRY
`endif
);

  state_t           state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [2:0]       op_q, op_nx;
  logic             err_q;
  logic             accept, step, cnt_last;
  logic [AMT_W-1:0] unused_cnt;
  logic             unused_q_mid;

  assign accept = (state_q == IDLE) && START;
  assign op_nx  = accept ? OP : op_q;

  // S is registered, so a step is whatever the slices actually see: SHIFT with a
  // non-HOLD mode. STALL therefore gates the mode presented on the following cycle.
  assign step = (state_q == SHIFT) && (mode_q != MODE_HOLD);

  shift_cnt #(.AMT_W(AMT_W)) u_cnt (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .load     (accept),
    .load_val (AMT),
    .en       (step),
    .count    (unused_cnt),
    .last     (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = MODE_HOLD;
    case (state_q)
      IDLE: begin
        if (START) begin
          if (!op_legal(OP))      state_d = FIN;
          else if (OP == OP_LOAD) state_d = LOAD;
          else if (AMT == '0)     state_d = FIN;
          else                    state_d = SHIFT;
        end
      end
      LOAD:    if (mode_q == MODE_LOAD) state_d = FIN;
      SHIFT:   if (step && cnt_last)    state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    case (state_d)
      LOAD:    mode_d = MODE_LOAD;
      SHIFT:   mode_d = shift_mode(op_nx);
      default: mode_d = MODE_HOLD;
    endcase
    if (STALL && ((state_q == LOAD) || (state_q == SHIFT))) mode_d = MODE_HOLD;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      mode_q  <= MODE_HOLD;
      op_q    <= OP_LOAD;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      if (accept) begin
        op_q  <= OP;
        err_q <= !op_legal(OP);
      end
    end
  end

  assign {S1, S0} = mode_q;
  assign BUSY     = (state_q != IDLE);
  assign DONE     = (state_q == FIN);
  assign ERR      = DONE && err_q;

  // End serial bits: only the feeding end of the active op is ever non-zero.
  always_comb begin
    LIN = 1'b0;
    RIN = 1'b0;
    if (state_q == SHIFT) begin
      case (op_q)
        OP_ROL:  LIN = REG_Q[WIDTH-1];
        OP_SRA:  RIN = REG_Q[WIDTH-1];
        OP_ROR:  RIN = REG_Q[0];
        default: ;
      endcase
    end
  end

  assign unused_q_mid = ^REG_Q[WIDTH-2:1];

`ifdef SHIFT_SEQ_CARRY_EN
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET)       CARRY <= 1'b0;
    else if (accept) CARRY <= 1'b0;
    else if (step)   CARRY <= op_left(op_q) ? REG_Q[WIDTH-1] : REG_Q[0];
  end
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural slice bank and expected-result queue.
module tb_shift_seq_ctrl;
  import shift_seq_pkg::*;

  localparam int W  = 16;
  localparam int AW = 4;

  logic          CLOCK = 1'b0;
  logic          RESET, START, STALL;
  logic [2:0]    OP;
  logic [AW-1:0] AMT;
  logic          S1, S0, LIN, RIN, BUSY, DONE, ERR;
`ifdef SHIFT_SEQ_CARRY_EN
  logic          CARRY;
`endif

  logic [W-1:0] bank  = '0;
  logic [W-1:0] pdata = '0;
  logic [W-1:0] model_val = '0;

  typedef struct {
    logic [W-1:0] val;
    logic         err;
    int           busy;
    int           steps;
    int           loads;
  } exp_t;
  exp_t sb[$];

  int total  = 0;
  int passed = 0;

  shift_seq_ctrl #(.WIDTH(W), .AMT_W(AW)) dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .START (START),
    .OP    (OP),
    .AMT   (AMT),
    .STALL (STALL),
    .REG_Q (bank),
    .S1    (S1),
    .S0    (S0),
    .LIN   (LIN),
    .RIN   (RIN),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .ERR   (ERR)
`ifdef SHIFT_SEQ_CARRY_EN
    ,
    .CARRY (CARRY)
`endif
  );

  always #5 CLOCK = ~CLOCK;

  // Universal shift-register bank built from the slices' shared controls.
  always_ff @(posedge CLOCK) begin
    case ({S1, S0})
      2'b11:   bank <= pdata;
      2'b10:   bank <= {bank[W-2:0], LIN};
      2'b01:   bank <= {RIN, bank[W-1:1]};
      default: bank <= bank;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  function automatic logic [W-1:0] ref_op(input logic [2:0] op, input int amt,
                                          input logic [W-1:0] v, input logic [W-1:0] ld);
    logic [W-1:0] r;
    r = v;
    if (op == 3'b000) return ld;
    if (op > 3'b101) return v;
    for (int i = 0; i < amt; i++) begin
      case (op)
        3'b001:  r = {r[W-2:0], 1'b0};
        3'b010:  r = {1'b0, r[W-1:1]};
        3'b011:  r = {r[W-1], r[W-1:1]};
        3'b100:  r = {r[W-2:0], r[W-1]};
        3'b101:  r = {r[0], r[W-1:1]};
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic run_cmd(input string tag, input logic [2:0] op, input int amt,
                         input logic [W-1:0] ld, input int stall_at, input int stall_len,
                         input bit fin_start);
    exp_t e, got;
    int   c, steps, loads, sbad;
    bit   seen, left, ill;
    left    = (op == 3'b001) || (op == 3'b100);
    ill     = (op > 3'b101);
    e.val   = ref_op(op, amt, model_val, ld);
    e.err   = ill;
    e.busy  = (op == 3'b000) ? 2 : (ill || amt == 0) ? 1 : amt + 1 + stall_len;
    e.steps = (ill || op == 3'b000) ? 0 : amt;
    e.loads = (op == 3'b000) ? 1 : 0;
    sb.push_back(e);
    model_val = e.val;

    @(negedge CLOCK);
    START = 1'b1; OP = op; AMT = amt[AW-1:0]; pdata = ld;
    @(posedge CLOCK); #1;
    START = 1'b0; OP = 3'($urandom); AMT = AW'($urandom);
    c = 0; steps = 0; loads = 0; sbad = 0; seen = 0;
    while (!seen && c < 60) begin
      @(negedge CLOCK);
      c++;
      if ({S1, S0} == 2'b11) loads++;
      if ({S1, S0} == 2'b10) begin
        steps++;
        if (!left) sbad++;
        if (LIN !== ((op == 3'b100) ? bank[W-1] : 1'b0) || RIN !== 1'b0) sbad++;
      end
      if ({S1, S0} == 2'b01) begin
        steps++;
        if (left) sbad++;
        if (RIN !== ((op == 3'b011) ? bank[W-1] : (op == 3'b101) ? bank[0] : 1'b0) ||
            LIN !== 1'b0) sbad++;
      end
      if (DONE === 1'b1) begin
        seen = 1;
        if ({LIN, RIN} !== 2'b00) sbad++;
        if (sb.size() == 0) chk({tag, "_queue"}, 0, 1);
        else begin
          got = sb.pop_front();
          chk({tag, "_result"}, bank, got.val);
          chk({tag, "_err"},    ERR,  got.err);
          chk({tag, "_busy"},   c,    got.busy);
          chk({tag, "_busyhi"}, BUSY, 1);
          chk({tag, "_steps"},  steps, got.steps);
          chk({tag, "_loads"},  loads, got.loads);
          chk({tag, "_serial"}, sbad, 0);
        end
      end
      STALL = (c >= stall_at) && (c < stall_at + stall_len);
      if (seen && fin_start) begin
        START = 1'b1; OP = 3'b001; AMT = AW'(3);
      end
    end
    STALL = 1'b0;
    if (!seen) begin
      chk({tag, "_timeout"}, 0, 1);
      void'(sb.pop_front());
    end
    @(negedge CLOCK);
    chk({tag, "_idle"}, {BUSY, DONE, ERR, S1, S0}, 0);
    START = 1'b0;
  endtask

  initial begin
    int dones;
    RESET = 1'b1; START = 1'b0; STALL = 1'b0; OP = '0; AMT = '0;
    #1;
    chk("reset_outs", {S1, S0, LIN, RIN, BUSY, DONE, ERR}, 0);
    repeat (2) @(posedge CLOCK);
    @(negedge CLOCK);
    RESET = 1'b0;

    run_cmd("load_a5c3", OP_LOAD, 0, 16'hA5C3, 0, 0, 0);
    run_cmd("load_8001", OP_LOAD, 0, 16'h8001, 0, 0, 0);
    run_cmd("rol1",      OP_ROL,  1, 16'h0,    0, 0, 0);
    run_cmd("load_8000", OP_LOAD, 0, 16'h8000, 0, 0, 0);
    run_cmd("sra3",      OP_SRA,  3, 16'h0,    0, 0, 0);
    run_cmd("load_ffff", OP_LOAD, 0, 16'hFFFF, 0, 0, 0);
    run_cmd("srl4_stall", OP_SRL, 4, 16'h0,    2, 2, 0);
    run_cmd("illegal6",  3'b110,  3, 16'h0,    0, 0, 0);
    run_cmd("sll0_finstart", OP_SLL, 0, 16'h0, 0, 0, 1);
    run_cmd("ror15",     OP_ROR, 15, 16'h0,    0, 0, 0);
    run_cmd("illegal7",  3'b111,  0, 16'h0,    0, 0, 0);

    // Reset in the middle of a shift: the command must vanish without DONE.
    run_cmd("load_0001", OP_LOAD, 0, 16'h0001, 0, 0, 0);
    @(negedge CLOCK);
    START = 1'b1; OP = OP_SLL; AMT = AW'(5);
    @(posedge CLOCK); #1;
    START = 1'b0;
    repeat (2) @(posedge CLOCK);
    #2 RESET = 1'b1;
    #1;
    chk("rst_async", {S1, S0, BUSY, DONE, ERR}, 0);
    @(negedge CLOCK);
    RESET = 1'b0;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLOCK);
      if (DONE === 1'b1) dones++;
    end
    chk("rst_nodone", dones, 0);
    chk("rst_bank",   bank, 16'h0004);
    chk("rst_idle",   {BUSY, S1, S0}, 0);
    model_val = 16'h0004;

    run_cmd("load_1b", OP_LOAD, 0, 16'h0001, 0, 0, 0);
`ifdef SHIFT_SEQ_CARRY_EN
    chk("carry_after_load", CARRY, 0);
`endif
    run_cmd("ror1", OP_ROR, 1, 16'h0, 0, 0, 0);
`ifdef SHIFT_SEQ_CARRY_EN
    chk("carry_ror1", CARRY, 1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
